// File: rtl/audio_out_fifo.sv
// Show-ahead stereo sample FIFO between the filter output strobe and the codec write port.
// Latency: a pair pushed on edge N is presented and write-eligible in cycle N+1.
// Backpressure: none upstream; pushes while full are discarded and counted, write_ready stalls the head.
module audio_out_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [W-1:0]             in_left,
  input  logic [W-1:0]             in_right,
  input  logic                     write_ready,
  output logic                     write,
  output logic [W-1:0]             writedata_left,
  output logic [W-1:0]             writedata_right,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [15:0]   DROP_MAX = 16'hFFFF;

  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [AW:0]    count_q, count_d;
  logic [15:0]    drop_q, drop_d;
  logic [2*W-1:0] mem_q [DEPTH];
  logic [2*W-1:0] mem_d [DEPTH];

  logic push;
  logic drop;
  logic pop;

  // Status flags come straight off the registered count; full gates push on
  // the pre-pop value, so a push into a full FIFO is dropped even if a pop
  // frees a slot on the same edge.
  always_comb begin
    empty           = (count_q == '0);
    full            = (count_q == CNT_FULL);
    count           = count_q;
    drop_cnt        = drop_q;
    push            = en & ~full;
    drop            = en & full;
    // Reset suppresses the handshake so nothing leaves while state is cleared.
    pop             = write_ready & ~empty & ~rst;
    write           = pop;
    writedata_left  = mem_q[rp_q][2*W-1:W];
    writedata_right = mem_q[rp_q][W-1:0];
  end

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    if (drop && drop_q != DROP_MAX) drop_d = drop_q + 16'd1;
  end

  // Storage write: the incoming pair lands at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {in_left, in_right};
  end

  // Control state with synchronous reset taking priority over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Sample storage is not reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_audio_out_fifo.sv
// Directed and randomized checks of audio_out_fifo against a queue-based model.
// Inputs driven at negedge, outputs sampled 1ns later, model updated at posedge.
// Covers reset, single pair, overrun, full push+pop, streaming wrap, mid-stream reset.
module tb_audio_out_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  in_left;
  logic [W-1:0]  in_right;
  logic          write_ready;
  logic          write;
  logic [W-1:0]  writedata_left;
  logic [W-1:0]  writedata_right;
  logic          empty;
  logic          full;
  logic [3:0]    count;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int passes = 0;

  logic [2*W-1:0] mq[$];
  int             m_drops = 0;

  audio_out_fifo #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_left(in_left), .in_right(in_right),
    .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .empty(empty), .full(full), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare all visible outputs with the model, then advance one clock.
  task automatic cycle(input bit e, input logic [W-1:0] l, input logic [W-1:0] r, input bit wr);
    bit exp_wr;
    bit was_full;
    en = e; in_left = l; in_right = r; write_ready = wr;
    #1;
    exp_wr = wr && (mq.size() > 0);
    check("write", write, exp_wr);
    if (mq.size() > 0) begin
      check("wd_left", writedata_left, mq[0][2*W-1:W]);
      check("wd_right", writedata_right, mq[0][W-1:0]);
    end
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("drop_cnt", drop_cnt, m_drops);
    @(posedge clk);
    was_full = (mq.size() == DEPTH);
    if (exp_wr) void'(mq.pop_front());
    if (e) begin
      if (!was_full) mq.push_back({l, r});
      else if (m_drops < 65535) m_drops++;
    end
    @(negedge clk);
  endtask

  task automatic reset_cycles(input int n, input bit e, input bit wr);
    rst = 1'b1; en = e; write_ready = wr; in_left = 24'd123; in_right = 24'd456;
    for (int i = 0; i < n; i++) begin
      #1;
      check("write_in_reset", write, 1'b0);
      @(posedge clk);
      mq.delete();
      m_drops = 0;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_drop", drop_cnt, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_left = '0; in_right = '0; write_ready = 1'b0;

    // Reset then idle with the codec ready.
    reset_cycles(2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1);

    // Single pair, one-cycle latency to the write.
    cycle(1'b1, 24'd50, 24'hFFFFCE, 1'b1);
    #0;
    check("single_write", write, 1'b1);
    check("single_left", writedata_left, 24'd50);
    check("single_right", writedata_right, 24'hFFFFCE);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);

    // Fill and overrun with the codec stalled.
    for (int i = 1; i <= 10; i++) cycle(1'b1, W'(i), W'(i + 100), 1'b0);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 8);
    check("fill_drops", drop_cnt, 2);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", writedata_left, i);
      cycle(1'b0, '0, '0, 1'b1);
    end
    check("drain_empty", empty, 1'b1);

    // Full with simultaneous push and pop: pop wins, push is dropped.
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), W'(i), 1'b0);
    cycle(1'b1, 24'd9, 24'd9, 1'b1);
    check("fullpp_count", count, 7);
    check("fullpp_drops", drop_cnt, 3);
    check("fullpp_head", writedata_left, 2);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b1);

    // Streaming with pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 24'd60 : 24'd40, (i % 2 == 0) ? 24'd40 : 24'd60, 1'b1);
      check("stream_count_le1", count <= 1, 1'b1);
    end
    cycle(1'b0, '0, '0, 1'b1);
    check("stream_drops", drop_cnt, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0) ^ (i >= 200));
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b1);

    // Reset mid-stream with a push offered during reset.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(200 + i), W'(300 + i), 1'b0);
    check("pre_reset_count", count, 5);
    reset_cycles(1, 1'b1, 1'b1);
    cycle(1'b1, 24'd70, 24'd71, 1'b1);
    check("post_reset_first", writedata_left, 24'd70);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
